// File: rtl/replica_timing_monitor.sv
// rtl/replica_timing_monitor.sv - critical-path replica launch/capture error monitor with windowed slow-down request
module replica_timing_monitor #(
    parameter int INVERT = 0,
    parameter int WINDOW = 16,
    parameter int THRESH = 2,
    parameter int CNT_W  = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             launch_o,
    input  logic             replica_i,
    output logic             err_o,
    output logic             slow_req_o,
    output logic [CNT_W-1:0] err_count_o
);

    localparam int WC_W = (WINDOW > 2) ? $clog2(WINDOW) : 1;
    localparam int WE_W = $clog2(WINDOW + 1);

    localparam logic [WC_W-1:0]  WIN_LAST = WC_W'(WINDOW - 1);
    localparam logic [WE_W-1:0]  THRESH_V = WE_W'(THRESH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic             INV_BIT  = (INVERT != 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        ALARM = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic             launch_q;
    logic             exp1_q;
    logic             v1_q;
    logic             cap_q;
    logic             exp2_q;
    logic             v2_q;
    logic             err_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [WC_W-1:0]  win_cnt_q;
    logic [WE_W-1:0]  win_err_q;

    logic             mismatch;
    logic             win_last;
    logic [WE_W-1:0]  win_err_inc;
    logic             thresh_hit;
    logic             quiet_close;
    logic             win_track;

    // Launch stage: toggle every enabled cycle and remember what the replica should return.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            launch_q <= 1'b0;
            exp1_q   <= 1'b0;
            v1_q     <= 1'b0;
        end else if (en_i) begin
            launch_q <= ~launch_q;
            exp1_q   <= ~launch_q ^ INV_BIT;
            v1_q     <= 1'b1;
        end else begin
            v1_q     <= 1'b0;
        end
    end

    // Capture stage: cap_q samples the raw replica output directly so the full cycle is the path budget.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cap_q  <= 1'b0;
            exp2_q <= 1'b0;
            v2_q   <= 1'b0;
        end else begin
            cap_q  <= replica_i;
            exp2_q <= exp1_q;
            v2_q   <= v1_q;
        end
    end

    assign mismatch    = v2_q & (cap_q ^ exp2_q);
    assign win_last    = v2_q && (win_cnt_q == WIN_LAST);
    assign win_err_inc = win_err_q + WE_W'(mismatch);
    assign thresh_hit  = mismatch && (win_err_inc >= THRESH_V);
    assign quiet_close = win_last && (win_err_inc == '0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            err_q <= mismatch;
            if (clr_i) begin
                err_cnt_q <= '0;
            end else if (mismatch && (err_cnt_q != CNT_MAX)) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    // Window bookkeeping only runs while the FSM is tracking; in-flight compares after a disable are ignored.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else if (!win_track) begin
            win_cnt_q <= '0;
            win_err_q <= '0;
        end else if (v2_q) begin
            if (win_last) begin
                win_cnt_q <= '0;
                win_err_q <= '0;
            end else begin
                win_cnt_q <= win_cnt_q + WC_W'(1);
                win_err_q <= win_err_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!en_i) begin
            state_d = IDLE;
        end else if (clr_i) begin
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE:    state_d = RUN;
                RUN:     if (thresh_hit) state_d = ALARM;
                ALARM:   if (quiet_close) state_d = RUN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        slow_req_o = 1'b0;
        win_track  = 1'b0;
        case (state_q)
            RUN: begin
                win_track = en_i & ~clr_i;
            end
            ALARM: begin
                slow_req_o = 1'b1;
                win_track  = en_i & ~clr_i;
            end
            default: begin
                slow_req_o = 1'b0;
                win_track  = 1'b0;
            end
        endcase
    end

    assign launch_o    = launch_q;
    assign err_o       = err_q;
    assign err_count_o = err_cnt_q;

endmodule

// File: tb/tb_replica_timing_monitor.sv
// tb/tb_replica_timing_monitor.sv - directed self-checking bench for replica_timing_monitor
module tb_replica_timing_monitor;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic        slow_mode;

    logic        launch_a;
    logic        replica_a;
    logic        launch_da;
    logic        err_a;
    logic        slow_a;
    logic [15:0] cnt_a;

    logic        launch_b;
    logic        replica_b;
    logic        launch_db;
    logic        err_b;
    logic        slow_b;
    logic [3:0]  cnt_b;

    logic        exp_launch;
    int          n_checks;
    int          n_errs;

    replica_timing_monitor u_dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .clr_i       (clr),
        .launch_o    (launch_a),
        .replica_i   (replica_a),
        .err_o       (err_a),
        .slow_req_o  (slow_a),
        .err_count_o (cnt_a)
    );

    replica_timing_monitor #(.CNT_W(4)) u_sat (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .en_i        (en),
        .clr_i       (clr),
        .launch_o    (launch_b),
        .replica_i   (replica_b),
        .err_o       (err_b),
        .slow_req_o  (slow_b),
        .err_count_o (cnt_b)
    );

    // Fast replica: combinational copy of launch. Slow replica: launch one cycle late.
    always @(posedge clk) begin
        launch_da <= launch_a;
        launch_db <= launch_b;
    end
    assign replica_a = slow_mode ? launch_da : launch_a;
    assign replica_b = slow_mode ? launch_db : launch_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic tick();
        if (en && rst_n) exp_launch = ~exp_launch;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        en  = 1'b0;
        clr = 1'b0;
        repeat (3) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("drain_cnt", 32'(cnt_a), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks   = 0;
        n_errs     = 0;
        rst_n      = 1'b0;
        en         = 1'b0;
        clr        = 1'b0;
        slow_mode  = 1'b0;
        exp_launch = 1'b0;
        repeat (3) tick();
        check("rst_launch", 32'(launch_a), 32'd0);
        check("rst_err",    32'(err_a),    32'd0);
        check("rst_slow",   32'(slow_a),   32'd0);
        check("rst_cnt",    32'(cnt_a),    32'd0);
        check("rst_satcnt", 32'(cnt_b),    32'd0);
        rst_n = 1'b1;
        tick();

        // Fast replica: never an error.
        en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            tick();
            check("fast_launch", 32'(launch_a), 32'(exp_launch));
            check("fast_err",    32'(err_a),    32'd0);
        end
        check("fast_cnt",  32'(cnt_a),  32'd0);
        check("fast_slow", 32'(slow_a), 32'd0);
        drain();

        // Slow replica: errors every cycle from the third edge, alarm on the second error, saturation at 15.
        slow_mode = 1'b1;
        en = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            check("slow_err",  32'(err_a),  32'(t >= 3));
            check("slow_slow", 32'(slow_a), 32'(t >= 4));
            check("slow_cnt",  32'(cnt_a),  (t >= 3) ? 32'(t - 2) : 32'd0);
            check("sat_cnt",   32'(cnt_b),  (t >= 17) ? 32'd15 : ((t >= 3) ? 32'(t - 2) : 32'd0));
        end
        drain();

        // Three errors, then a clean replica: alarm holds until the second window closes clean.
        slow_mode = 1'b1;
        en = 1'b1;
        for (int t = 1; t <= 40; t++) begin
            if (t == 5) slow_mode = 1'b0;
            tick();
            check("rec_err",  32'(err_a),  32'((t >= 3) && (t <= 5)));
            check("rec_slow", 32'(slow_a), 32'((t >= 4) && (t <= 33)));
        end
        check("rec_cnt", 32'(cnt_a), 32'd3);
        drain();

        // Disable mid-flight: two compares still in the pipe pulse err_o, launch freezes.
        slow_mode = 1'b1;
        en = 1'b1;
        repeat (5) tick();
        check("dis_pre_slow", 32'(slow_a), 32'd1);
        en = 1'b0;
        tick();
        check("dis6_err",    32'(err_a),    32'd1);
        check("dis6_slow",   32'(slow_a),   32'd0);
        check("dis6_cnt",    32'(cnt_a),    32'd4);
        check("dis6_launch", 32'(launch_a), 32'(exp_launch));
        tick();
        check("dis7_err",    32'(err_a),    32'd1);
        check("dis7_cnt",    32'(cnt_a),    32'd5);
        tick();
        check("dis8_err",    32'(err_a),    32'd0);
        check("dis8_cnt",    32'(cnt_a),    32'd5);
        check("dis8_launch", 32'(launch_a), 32'(exp_launch));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("dis_clr_cnt", 32'(cnt_a), 32'd0);
        drain();

        // clr in alarm wins over a simultaneous mismatch, then async reset mid-run.
        slow_mode = 1'b1;
        en = 1'b1;
        repeat (5) tick();
        check("clr_pre_cnt",  32'(cnt_a),  32'd3);
        check("clr_pre_slow", 32'(slow_a), 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr_err",  32'(err_a),  32'd1);
        check("clr_cnt",  32'(cnt_a),  32'd0);
        check("clr_slow", 32'(slow_a), 32'd0);
        tick();
        check("clr7_cnt",  32'(cnt_a),  32'd1);
        check("clr7_slow", 32'(slow_a), 32'd0);
        tick();
        check("clr8_cnt",  32'(cnt_a),  32'd2);
        check("clr8_slow", 32'(slow_a), 32'd1);
        #3;
        rst_n = 1'b0;
        en = 1'b0;
        exp_launch = 1'b0;
        #1;
        check("arst_launch", 32'(launch_a), 32'd0);
        check("arst_err",    32'(err_a),    32'd0);
        check("arst_slow",   32'(slow_a),   32'd0);
        check("arst_cnt",    32'(cnt_a),    32'd0);
        check("arst_satcnt", 32'(cnt_b),    32'd0);
        #2;
        rst_n = 1'b1;
        slow_mode = 1'b0;
        en = 1'b1;
        tick();
        check("post_launch1", 32'(launch_a), 32'd1);
        check("post_satl1",   32'(launch_b), 32'd1);
        tick();
        check("post_launch2", 32'(launch_a), 32'd0);
        tick();
        check("post_err",     32'(err_a),    32'd0);
        check("post_slow",    32'(slow_a),   32'd0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/replica_timing_monitor.md
# replica_timing_monitor

Timing-error monitor driving the load/store critical-path delay replica (76-inverter chain, non-inverting) and consuming its output. Every enabled cycle it launches a toggle into the replica, captures the replica output at the next clock edge, and compares it with the launched value; a mismatch means the replica, and therefore the real LSU path, missed the cycle. It counts errors per observation window and raises a level request to the clock/stall controller when the error rate reaches a threshold.

## Interface
- INVERT, 0, 1 if the attached replica has an odd inverter count (expected capture = launched value XOR INVERT)
- WINDOW, 16, compared cycles per observation window (≥2)
- THRESH, 2, errors within one window that trigger the alarm (1..WINDOW)
- CNT_W, 16, width of the total error counter
- clk_i  in  1  single clock
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  monitoring enable
- clr_i  in  1  synchronous clear of counters and alarm
- launch_o  out  1  toggle stimulus into replica input
- replica_i  in  1  replica output; raw path, no synchronizer (sampled deliberately at the edge)
- err_o  out  1  one-cycle pulse per detected mismatch
- slow_req_o  out  1  level request for clock stretch/stall
- err_count_o  out  CNT_W  total errors since reset/clear, saturating

## Operation
- Reset: launch_o=0, err_o=0, slow_req_o=0, err_count_o=0, all valid/expect/capture flops 0, window counters 0, state IDLE.
- Pipeline, per edge k with en_i=1: launch_q<=~launch_q; exp1_q<=~launch_q^INVERT; v1_q<=1. With en_i=0: launch_q holds, v1_q<=0.
- Edge k+1: cap_q<=replica_i; exp2_q<=exp1_q; v2_q<=v1_q. mismatch = v2_q & (cap_q!=exp2_q).
- Edge k+2: err_o<=mismatch; on mismatch err_count_o increments, saturating at 2^CNT_W-1.
- Window: win_cnt increments on every v2_q cycle, wraps WINDOW-1 -> 0; win_err counts mismatches in current window, reset to 0 on wrap (the mismatch on the wrap cycle counts in the closing window).
- FSM states: IDLE, RUN, ALARM.
  - IDLE: slow_req_o=0; en_i=1 -> RUN.
  - RUN: win_err reaching THRESH (including the current mismatch) -> ALARM same edge err_o asserts.
  - ALARM: slow_req_o=1; a full window closing with win_err=0 (including current cycle) -> RUN.
  - Any state, en_i=0 -> IDLE; win_cnt/win_err reset to 0; err_count_o retained.
- Disable mid-flight: comparisons already in v1/v2 complete and may pulse err_o and count; they do not affect FSM or window (state already IDLE).
- clr_i=1: err_count_o, win_cnt, win_err <=0; ALARM -> RUN (IDLE if en_i=0); pipeline flops unaffected; clr_i wins over a simultaneous mismatch for counters, err_o still pulses.
- Reset asserted mid-operation: all state returns to reset values immediately, asynchronously.

## Timing
- Launch edge to err_o high: 2 cycles; err_o high exactly 1 cycle per mismatch.
- Mismatch to slow_req_o: same edge as err_o (registered FSM).
- First compare after en_i rise: launch at first edge with en_i=1, err_o valid 2 edges later; no spurious compare from IDLE.
- Continuous enable: one compare per cycle, no bubbles.
- Replica path budget: launch_o clock-to-q + replica + setup of cap_q must fit one cycle; launch_q and cap_q are dedicated flops, no logic between cap_q D and replica_i.

## Test plan
- Fast model (replica_i = launch_o^INVERT combinational), en_i=1 for 100 cycles -> launch_o toggles every cycle, err_o never high, err_count_o=0, slow_req_o=0.
- Slow model (replica_i = launch_o delayed one cycle), THRESH=2 -> err_o pulses every cycle from 2nd edge after enable, slow_req_o rises with 2nd err_o, err_count_o increments by 1 per cycle.
- Alarm recovery: slow model for 4 cycles then fast model -> slow_req_o drops at close of the first window with zero errors (WINDOW=16), not earlier.
- Saturation: CNT_W=4, slow model 30 cycles -> err_count_o stops at 15.
- en_i dropped after 5 slow cycles -> launch_o freezes, 2 in-flight err_o pulses still occur, state IDLE, slow_req_o=0 next edge; clr_i then -> err_count_o=0.
- rst_ni asserted asynchronously mid-run -> all outputs 0 without clock edge; release then en_i=1 -> normal launch resumes from launch_o=0.
